oam_line_arbiter: RTL and testbench
===================================

Name: oam_line_arbiter

Overview:
Per-scanline scheduler and OAM port arbiter for the sprite line-preparation engine. It triggers one OAM scan per visible line at a fixed horizontal position and supplies the target line number. During the scan it gives the single OAM port to the scan engine; otherwise it gives the port to CPU-side reads and writes. It reports scan completion (line_ready) and scan overruns to the sprite renderer.

Parameters:
SCAN_X, 640, sx value at which the scan for the next line is triggered
H_TOTAL, 800, pixels per line including blanking
V_ACTIVE, 480, visible lines; scans are issued only for target lines 0..V_ACTIVE-1
V_TOTAL, 525, lines per frame; the target line wraps to 0 after V_TOTAL-1
OAM_AW, 6, OAM word address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sx  in  10  current pixel column
sy  in  10  current line
cpu_req  in  1  CPU OAM access request; held high until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  OAM_AW  CPU word address
cpu_wdata  in  32  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  32  read data, valid while cpu_ack = 1
scan_start  out  1  one-cycle pulse that starts the scan engine
scan_line  out  10  line the engine must evaluate
scan_addr  in  OAM_AW  OAM address driven by the engine
scan_done  in  1  engine finished (pulse or level; the first high cycle counts)
scan_stall  out  1  engine must hold its address/state this cycle
oam_addr  out  OAM_AW  OAM port address
oam_we  out  1  OAM write enable
oam_wdata  out  32  OAM write data
oam_rdata  in  32  OAM read data; synchronous, 1-cycle latency
line_ready  out  1  buffer for scan_line is complete
overrun  out  1  sticky scan-overrun flag

Behaviour:
- Reset: state IDLE. All outputs are 0, including scan_line and overrun. pending is cleared. Reset asserted mid-scan or mid-CPU-access aborts it with no cpu_ack.
- Trigger: trig = (sx == SCAN_X). next_line = (sy == V_TOTAL-1) ? 0 : sy+1. A trigger is valid only when next_line < V_ACTIVE.
- States are IDLE, CPU_ADDR, CPU_DATA and SCAN.
- IDLE:
  - A valid trigger has priority: go to SCAN, latch scan_line = next_line, pulse scan_start on the entry cycle, clear line_ready.
  - Otherwise, cpu_req = 1: go to CPU_ADDR.
  - oam_addr and oam_we are 0 in IDLE.
- CPU_ADDR: oam_addr = cpu_addr, oam_we = cpu_we, oam_wdata = cpu_wdata. Next state is CPU_DATA.
- CPU_DATA:
  - cpu_ack = 1; cpu_rdata = oam_rdata, registered pass-through.
  - If pending = 1, go to SCAN with the latched line and clear pending. Otherwise go to IDLE.
  - CPU latency from an idle port: cpu_ack 2 cycles after cpu_req is sampled.
- A valid trigger arriving in CPU_ADDR or CPU_DATA sets pending and latches next_line. The CPU access always completes first.
- SCAN:
  - oam_addr = scan_addr, oam_we = 0.
  - The first cycle with scan_done = 1 moves to IDLE and sets line_ready = 1, held until the next scan_start.
  - CPU requests wait, with no ack.
- Overrun: a valid trigger while in SCAN sets overrun (sticky until reset). It also re-latches scan_line, re-pulses scan_start and keeps line_ready = 0. The scan restarts for the new line.
- Simultaneous scan_done and trigger in SCAN: the trigger wins. No overrun is set, line_ready pulses for exactly 1 cycle, then the new scan starts.
- Invalid triggers (blanking lines) are ignored; line_ready keeps its value.
- scan_stall = 0 at all times unless the feature below is enabled.

Optional Feature:
OAM_CPU_INTERLEAVE_EN
- Defined:
  - In SCAN with cpu_req = 1, the arbiter alternates: every second SCAN cycle is a CPU slot (a phase bit starts at 0 on SCAN entry; the slot is when phase = 1).
  - In a CPU slot: scan_stall = 1, oam_addr = cpu_addr, oam_we = cpu_we. cpu_ack with cpu_rdata follows on the next cycle, which is a scan cycle.
  - One CPU access per slot.
- Undefined: CPU accesses wait for IDLE, scan_stall is tied 0, and the phase logic is absent.

Test Plan:
1. Reset mid-CPU-write (cpu_addr = 5, cpu_we = 1, reset on the CPU_ADDR cycle) -> no cpu_ack, all outputs 0, OAM[5] is not required to change.
2. Idle read: cpu_req = 1, cpu_we = 0, cpu_addr = 3 with OAM[3] = 0xA5A5_0001 -> cpu_ack 2 cycles later with cpu_rdata = 0xA5A5_0001, oam_we = 0 throughout.
3. sy = 10, sx reaches 640 -> scan_start pulse and scan_line = 11; oam_addr follows scan_addr. scan_done after 20 cycles -> line_ready = 1 until the next trigger.
4. sy = 524 trigger -> scan_line = 0. sy = 479 and sy = 500 triggers -> no scan_start, line_ready unchanged.
5. Trigger on the CPU_ADDR cycle of a write -> cpu_ack completes, SCAN is entered the next cycle with scan_start = 1. Trigger while in SCAN (no scan_done) -> overrun = 1 and the scan restarts. Trigger and scan_done on the same cycle -> overrun stays 0.
6. With OAM_CPU_INTERLEAVE_EN: cpu_req during SCAN -> scan_stall = 1 on the 2nd SCAN cycle, cpu_ack on the 3rd. Without the macro -> cpu_ack only after scan_done, 2 cycles after IDLE is entered.

Source files
------------

// File: rtl/oam_line_arbiter.sv
// Per-scanline OAM scan scheduler and single-port OAM arbiter (scan engine vs CPU).
// Optional build macro OAM_CPU_INTERLEAVE_EN: CPU accesses steal every second SCAN cycle.
module oam_line_arbiter #(
    parameter int unsigned SCAN_X   = 640,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned OAM_AW   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        sx,
    input  logic [9:0]        sy,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [OAM_AW-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    output logic              scan_start,
    output logic [9:0]        scan_line,
    input  logic [OAM_AW-1:0] scan_addr,
    input  logic              scan_done,
    output logic              scan_stall,
    output logic [OAM_AW-1:0] oam_addr,
    output logic              oam_we,
    output logic [31:0]       oam_wdata,
    input  logic [31:0]       oam_rdata,
    output logic              line_ready,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE,
        CPU_ADDR,
        CPU_DATA,
        SCAN
    } state_t;

    state_t     state;
    logic       pending;
    logic [9:0] pend_line;
    logic [9:0] next_line;
    logic       trig_valid;
    logic       slot;

    always_comb begin
        next_line  = (sy == 10'(V_TOTAL - 1)) ? '0 : sy + 10'd1;
        trig_valid = (sx == 10'(SCAN_X)) && (sx < 10'(H_TOTAL)) && (next_line < 10'(V_ACTIVE));
    end

`ifdef OAM_CPU_INTERLEAVE_EN
    logic phase;

    // The ack cycle of a slot still sees cpu_req high; never start a second access then.
    assign slot = (state == SCAN) && phase && cpu_req && !cpu_ack;
`else
    assign slot = 1'b0;
`endif

    // OAM port mux follows the state directly so the engine's address reaches OAM the same cycle.
    always_comb begin
        oam_addr   = '0;
        oam_we     = 1'b0;
        oam_wdata  = '0;
        scan_stall = 1'b0;
        unique case (state)
            CPU_ADDR: begin
                oam_addr  = cpu_addr;
                oam_we    = cpu_we;
                oam_wdata = cpu_wdata;
            end
            SCAN: begin
                if (slot) begin
                    oam_addr   = cpu_addr;
                    oam_we     = cpu_we;
                    oam_wdata  = cpu_wdata;
                    scan_stall = 1'b1;
                end else begin
                    oam_addr = scan_addr;
                end
            end
            default: ;
        endcase
    end

    assign cpu_rdata = cpu_ack ? oam_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= 1'b0;
            pend_line  <= '0;
            scan_line  <= '0;
            scan_start <= 1'b0;
            cpu_ack    <= 1'b0;
            line_ready <= 1'b0;
            overrun    <= 1'b0;
`ifdef OAM_CPU_INTERLEAVE_EN
            phase      <= 1'b0;
`endif
        end else begin
            scan_start <= 1'b0;
            cpu_ack    <= 1'b0;
`ifdef OAM_CPU_INTERLEAVE_EN
            phase      <= (state == SCAN) ? ~phase : 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (trig_valid) begin
                        state      <= SCAN;
                        scan_line  <= next_line;
                        scan_start <= 1'b1;
                        line_ready <= 1'b0;
                        pending    <= 1'b0;
                    end else if (pending) begin
                        state      <= SCAN;
                        scan_line  <= pend_line;
                        scan_start <= 1'b1;
                        line_ready <= 1'b0;
                        pending    <= 1'b0;
                    end else if (cpu_req && !cpu_ack) begin
                        state <= CPU_ADDR;
                    end
                end
                CPU_ADDR: begin
                    if (trig_valid) begin
                        pending   <= 1'b1;
                        pend_line <= next_line;
                    end
                    state   <= CPU_DATA;
                    cpu_ack <= 1'b1;
                end
                CPU_DATA: begin
                    if (trig_valid) begin
                        state      <= SCAN;
                        scan_line  <= next_line;
                        scan_start <= 1'b1;
                        line_ready <= 1'b0;
                        pending    <= 1'b0;
                    end else if (pending) begin
                        state      <= SCAN;
                        scan_line  <= pend_line;
                        scan_start <= 1'b1;
                        line_ready <= 1'b0;
                        pending    <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    if (trig_valid && scan_done) begin
                        // Finished scan gets its one-cycle line_ready in IDLE before the new scan.
                        state      <= IDLE;
                        line_ready <= 1'b1;
                        pending    <= 1'b1;
                        pend_line  <= next_line;
                    end else if (trig_valid) begin
                        overrun    <= 1'b1;
                        scan_line  <= next_line;
                        scan_start <= 1'b1;
                        line_ready <= 1'b0;
`ifdef OAM_CPU_INTERLEAVE_EN
                        phase      <= 1'b0;
`endif
                    end else if (scan_done) begin
                        state      <= IDLE;
                        line_ready <= 1'b1;
                    end
`ifdef OAM_CPU_INTERLEAVE_EN
                    if (slot) begin
                        cpu_ack <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oam_line_arbiter.sv
// Directed bench for oam_line_arbiter with a behavioural 1-cycle-latency OAM.
// Covers both builds; OAM_CPU_INTERLEAVE_EN selects the interleave expectations.
module tb_oam_line_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  sx, sy;
    logic        cpu_req, cpu_we;
    logic [5:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        scan_start;
    logic [9:0]  scan_line;
    logic [5:0]  scan_addr;
    logic        scan_done;
    logic        scan_stall;
    logic [5:0]  oam_addr;
    logic        oam_we;
    logic [31:0] oam_wdata;
    logic [31:0] oam_rdata;
    logic        line_ready;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];

    oam_line_arbiter #(
        .SCAN_X(640), .H_TOTAL(800), .V_ACTIVE(480), .V_TOTAL(525), .OAM_AW(6)
    ) dut (
        .clk(clk), .reset(reset), .sx(sx), .sy(sy),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .scan_start(scan_start), .scan_line(scan_line), .scan_addr(scan_addr),
        .scan_done(scan_done), .scan_stall(scan_stall),
        .oam_addr(oam_addr), .oam_we(oam_we), .oam_wdata(oam_wdata), .oam_rdata(oam_rdata),
        .line_ready(line_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (oam_we) mem[oam_addr] <= oam_wdata;
        oam_rdata <= mem[oam_addr];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[3] = 32'hA5A5_0001;
        reset = 1'b1; sx = '0; sy = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        scan_addr = '0; scan_done = 1'b0;
        repeat (3) cyc();
        #1;
        check("rst_ack", 32'(cpu_ack), 0);
        check("rst_start", 32'(scan_start), 0);
        check("rst_line", 32'(scan_line), 0);
        check("rst_ready", 32'(line_ready), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_oam", {oam_wdata[23:0], 1'b0, oam_we, oam_addr}, 0);
        check("rst_stall", 32'(scan_stall), 0);

        // 1: reset lands on the CPU_ADDR cycle of a write
        cyc(); reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd5; cpu_wdata = 32'hDEAD_BEEF; #1;
        check("t1_idle_we", 32'(oam_we), 0);
        cyc(); #1;
        check("t1_addr_we", 32'(oam_we), 1);
        check("t1_addr_a", 32'(oam_addr), 5);
        reset = 1'b1;
        cyc(); #1;
        check("t1_no_ack", 32'(cpu_ack), 0);
        check("t1_oam_we", 32'(oam_we), 0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        cyc(); #1;
        check("t1_no_ack2", 32'(cpu_ack), 0);
        reset = 1'b0;

        // 2: idle read of OAM[3]
        cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd3; #1;
        cyc(); #1;
        check("t2_addr_a", 32'(oam_addr), 3);
        check("t2_addr_we", 32'(oam_we), 0);
        check("t2_early_ack", 32'(cpu_ack), 0);
        cyc(); #1;
        check("t2_ack", 32'(cpu_ack), 1);
        check("t2_rdata", cpu_rdata, 32'hA5A5_0001);
        check("t2_data_we", 32'(oam_we), 0);
        cpu_req = 1'b0;
        cyc(); #1;
        check("t2_ack_off", 32'(cpu_ack), 0);

        // 3: trigger at sy=10, scan of 20 cycles
        sy = 10'd10; sx = 10'd640; #1;
        cyc(); sx = 10'd641; scan_addr = 6'd7; #1;
        check("t3_start", 32'(scan_start), 1);
        check("t3_line", 32'(scan_line), 11);
        check("t3_ready0", 32'(line_ready), 0);
        check("t3_follow", 32'(oam_addr), 7);
        for (int i = 2; i <= 20; i++) begin
            cyc(); scan_addr = 6'(i + 20); scan_done = (i == 20); #1;
            if (i == 2) check("t3_start_off", 32'(scan_start), 0);
            if (i == 15) check("t3_follow2", 32'(oam_addr), 35);
        end
        check("t3_notready", 32'(line_ready), 0);
        cyc(); scan_done = 1'b0; #1;
        check("t3_ready", 32'(line_ready), 1);
        cyc(); cyc(); #1;
        check("t3_ready_held", 32'(line_ready), 1);

        // 4: wrap line and blanking triggers
        sy = 10'd524; sx = 10'd640; #1;
        cyc(); sx = 10'd641; scan_done = 1'b1; #1;
        check("t4_start", 32'(scan_start), 1);
        check("t4_line0", 32'(scan_line), 0);
        check("t4_ready0", 32'(line_ready), 0);
        cyc(); scan_done = 1'b0; #1;
        check("t4_ready", 32'(line_ready), 1);
        sy = 10'd479; sx = 10'd640;
        cyc(); sx = 10'd641; #1;
        check("t4_479_start", 32'(scan_start), 0);
        check("t4_479_ready", 32'(line_ready), 1);
        sy = 10'd500; sx = 10'd640;
        cyc(); sx = 10'd641; #1;
        check("t4_500_start", 32'(scan_start), 0);
        check("t4_500_ready", 32'(line_ready), 1);
        check("t4_500_line", 32'(scan_line), 0);

        // 5a: trigger during CPU_ADDR of a write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd9; cpu_wdata = 32'h1234_5678;
        cyc(); sy = 10'd20; sx = 10'd640; #1;
        check("t5_addr_we", 32'(oam_we), 1);
        cyc(); sx = 10'd641; #1;
        check("t5_ack", 32'(cpu_ack), 1);
        check("t5_nostart", 32'(scan_start), 0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        cyc(); #1;
        check("t5_start", 32'(scan_start), 1);
        check("t5_line", 32'(scan_line), 21);
        check("t5_ready0", 32'(line_ready), 0);
        // 5b: overrun
        cyc(); sy = 10'd21; sx = 10'd640; #1;
        check("t5_ovr0", 32'(overrun), 0);
        cyc(); sx = 10'd641; #1;
        check("t5_ovr", 32'(overrun), 1);
        check("t5_restart", 32'(scan_start), 1);
        check("t5_reline", 32'(scan_line), 22);
        cyc(); scan_done = 1'b1; #1;
        check("t5_ovr_sticky", 32'(overrun), 1);
        cyc(); scan_done = 1'b0; #1;
        reset = 1'b1;
        cyc(); reset = 1'b0; #1;
        check("t5_ovr_rst", 32'(overrun), 0);
        // 5c: trigger and scan_done together
        sy = 10'd30; sx = 10'd640;
        cyc(); sx = 10'd641; #1;
        check("t5c_line", 32'(scan_line), 31);
        cyc(); sy = 10'd31; sx = 10'd640; scan_done = 1'b1; #1;
        cyc(); sx = 10'd641; scan_done = 1'b0; #1;
        check("t5c_ovr", 32'(overrun), 0);
        check("t5c_ready", 32'(line_ready), 1);
        check("t5c_oldline", 32'(scan_line), 31);
        cyc(); #1;
        check("t5c_start", 32'(scan_start), 1);
        check("t5c_line2", 32'(scan_line), 32);
        check("t5c_ready_off", 32'(line_ready), 0);
        check("t5c_ovr2", 32'(overrun), 0);
        cyc(); scan_done = 1'b1; #1;
        cyc(); scan_done = 1'b0; #1;

        // 6: CPU request while scanning
        sy = 10'd40; sx = 10'd640;
        cyc(); sx = 10'd641; scan_addr = 6'd17;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd3; #1;
        check("t6_s1_stall", 32'(scan_stall), 0);
`ifdef OAM_CPU_INTERLEAVE_EN
        cyc(); #1;
        check("t6_slot_stall", 32'(scan_stall), 1);
        check("t6_slot_addr", 32'(oam_addr), 3);
        check("t6_slot_noack", 32'(cpu_ack), 0);
        cyc(); #1;
        check("t6_ack", 32'(cpu_ack), 1);
        check("t6_rdata", cpu_rdata, 32'hA5A5_0001);
        check("t6_s3_stall", 32'(scan_stall), 0);
        check("t6_s3_addr", 32'(oam_addr), 17);
        cpu_req = 1'b0; scan_done = 1'b1;
        cyc(); scan_done = 1'b0; #1;
        check("t6_idle_ack", 32'(cpu_ack), 0);
        check("t6_ready", 32'(line_ready), 1);
`else
        cyc(); #1;
        check("t6_s2_stall", 32'(scan_stall), 0);
        check("t6_s2_addr", 32'(oam_addr), 17);
        check("t6_s2_ack", 32'(cpu_ack), 0);
        cyc(); scan_done = 1'b1; #1;
        check("t6_s3_ack", 32'(cpu_ack), 0);
        cyc(); scan_done = 1'b0; #1;
        check("t6_idle_ack", 32'(cpu_ack), 0);
        check("t6_ready", 32'(line_ready), 1);
        cyc(); #1;
        check("t6_addr_ack", 32'(cpu_ack), 0);
        check("t6_addr_a", 32'(oam_addr), 3);
        cyc(); #1;
        check("t6_ack", 32'(cpu_ack), 1);
        check("t6_rdata", cpu_rdata, 32'hA5A5_0001);
        cpu_req = 1'b0;
`endif

        // 7: read back the write completed in 5a
        cyc(); cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd9; #1;
        cyc(); cyc(); #1;
        check("t7_ack", 32'(cpu_ack), 1);
        check("t7_rdata", cpu_rdata, 32'h1234_5678);
        cpu_req = 1'b0;
        cyc(); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
